// File: rtl/dmux_pkg.sv
// dmux_pkg: shared constants, the buffered entry type and the lane decode
// used by the dmux4_stream slice.
package dmux_pkg;

  localparam int DMUX_WIDTH = 16;  // default payload width
  localparam int LANES      = 4;   // number of output lanes
  localparam int CNT_W      = 16;  // width of each per-lane pop counter

  // One buffered transfer at the default payload width: destination lane
  // in the upper bits, payload below it.
  typedef struct packed {
    logic [1:0]            sel;
    logic [DMUX_WIDTH-1:0] data;
  } entry_t;

  // Lane number to one-hot lane mask.
  function automatic logic [LANES-1:0] lane_onehot(input logic [1:0] sel);
    logic [LANES-1:0] mask;
    mask      = '0;
    mask[sel] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/dmux4_stream_fifo2.sv
// fifo2: generic 2-entry in-order valid/ready FIFO.
// The push side ready is registered, so it depends only on the occupancy and
// never on the pop side handshake of the same cycle: a full FIFO refuses a
// push even while it is being popped.
module fifo2 #(
  parameter int DW    = 18,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_valid_i,
  output logic          push_ready_o,
  input  logic [DW-1:0] push_data_i,
  output logic          pop_valid_o,
  input  logic          pop_ready_i,
  output logic [DW-1:0] pop_data_o
);

  logic [DW-1:0] mem_q [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    count_q, count_d;
  logic          ready_q;
  logic          push;
  logic          pop;

  assign push = push_valid_i & ready_q;
  assign pop  = pop_ready_i & (count_q != 2'd0);

  // Next pointers and occupancy from this cycle's push/pop handshakes.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through this block can leave a value unassigned and infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Pointer, occupancy and registered push-ready state.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= (count_d < 2'(DEPTH));
    end
  end

  // Entry storage, written at the write pointer on an accepted push.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the occupancy count alone
    // decides whether an entry is live, so stale contents are never visible.
    if (push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign push_ready_o = ready_q;
  assign pop_valid_o  = (count_q != 2'd0);
  assign pop_data_o   = mem_q[rd_ptr_q];

endmodule

// File: rtl/dmux4_stream.sv
// dmux4_stream: 1-to-4 stream demultiplexer with a 2-entry buffer.
// Each accepted {in_sel, in_data} pair is delivered exactly once, in order,
// to the lane named by in_sel. out_data is shared by all lanes and holds its
// last value while the buffer is empty.
// Optional feature: define DMUX_CNT_EN to add the per-lane pop counter
// output cnt (lane n at bits [16n+15:16n]).
module dmux4_stream
  import dmux_pkg::*;
#(
  parameter int WIDTH = DMUX_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready
`ifdef DMUX_CNT_EN
  ,
  output logic [LANES*CNT_W-1:0] cnt
`endif
);

  // Entry at this instance's payload width; same layout as dmux_pkg::entry_t.
  typedef struct packed {
    logic [1:0]       sel;
    logic [WIDTH-1:0] data;
  } lane_entry_t;

  lane_entry_t      push_entry;
  lane_entry_t      head;
  logic             head_valid;
  logic [LANES-1:0] head_mask;
  logic             pop;
  logic [WIDTH-1:0] last_data_q;

  assign push_entry = '{sel: in_sel, data: in_data};

  fifo2 #(
    .DW    ($bits(lane_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (reset),
    .push_valid_i (in_valid),
    .push_ready_o (in_ready),
    .push_data_i  (push_entry),
    .pop_valid_o  (head_valid),
    .pop_ready_i  (pop),
    .pop_data_o   (head)
  );

  // Only the selected lane's ready can retire the head.
  assign head_mask = lane_onehot(head.sel);
  assign out_valid = head_valid ? head_mask : '0;
  assign pop       = |(out_valid & out_ready);
  assign out_data  = head_valid ? head.data : last_data_q;

  // Remember the head payload so out_data holds it once the buffer drains.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_data_q <= '0;
    end else if (head_valid) begin
      last_data_q <= head.data;
    end
  end

`ifdef DMUX_CNT_EN
  logic [CNT_W-1:0] cnt_q [LANES];

  // Count completed pops per lane; each counter wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < LANES; n++) cnt_q[n] <= '0;
    end else if (pop) begin
      cnt_q[head.sel] <= cnt_q[head.sel] + 1'b1;
    end
  end

  for (genvar n = 0; n < LANES; n++) begin : g_cnt
    assign cnt[n*CNT_W +: CNT_W] = cnt_q[n];
  end
`endif

endmodule

// File: doc/dmux4_stream.md
DMUX4_STREAM -- requirements
Module: dmux4_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width in bits.
REQ-002 SHALL have parameter DEPTH, fixed at 2, number of buffer entries.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_data, input, WIDTH bits: payload to route.
REQ-006 SHALL have port in_sel, input, 2 bits: destination lane 0..3, sampled with in_data.
REQ-007 SHALL have port in_valid, input, 1 bit: upstream offers in_data/in_sel.
REQ-008 SHALL have port in_ready, output, 1 bit: block accepts this cycle.
REQ-009 SHALL have port out_data, output, WIDTH bits: shared payload bus for all lanes.
REQ-010 SHALL have port out_valid, output, 4 bits: one-hot lane valid, bit n = lane n.
REQ-011 SHALL have port out_ready, input, 4 bits: per-lane consumer ready.

Function
REQ-012 SHALL hold accepted {in_sel, in_data} pairs in a 2-entry in-order FIFO.
REQ-013 SHALL push on a rising edge where in_valid && in_ready.
REQ-014 SHALL drive in_ready = 1 when the occupancy is 0 or 1, and 0 when it is 2; there is no combinational path from out_ready to in_ready.
REQ-015 SHALL, when non-empty, drive out_data = head data and out_valid = one-hot(head sel).
REQ-016 SHALL, when empty, drive out_valid = 4'b0000; out_data holds its last value.
REQ-017 SHALL pop the head on a rising edge where (out_valid & out_ready) != 0.
REQ-018 SHALL ignore out_ready bits of non-selected lanes.
REQ-019 SHALL have a latency of 1 cycle: data pushed into an empty FIFO shows out_valid on the next cycle.
REQ-020 SHALL, on a simultaneous push and pop with occupancy 1, keep occupancy at 1 and make the new entry the head.
REQ-021 SHALL, when full, refuse the push (in_ready = 0) even if a pop occurs in the same cycle.
REQ-022 SHALL keep head data and sel stable while out_valid is high and not yet accepted.
REQ-023 SHALL wrap the read/write pointers modulo 2 without loss of ordering.
REQ-024 SHALL not deliver an entry to more than one lane, nor deliver it more than once.

Reset
REQ-025 SHALL, while reset = 1, force occupancy 0, pointers 0, out_valid = 0, out_data = 0 and in_ready = 0.
REQ-026 SHALL, when reset asserts mid-transfer, discard all buffered entries with no partial delivery.
REQ-027 SHALL, on the first edge after reset deasserts, drive in_ready = 1.

Configuration
REQ-028 SHALL, with DMUX_CNT_EN defined, add output cnt (4x16 bits, lane n at bits [16n+15:16n]), a per-lane count of completed pops that wraps 16'hFFFF -> 0 and resets to 0.
REQ-029 SHALL, with DMUX_CNT_EN undefined, omit the cnt port and its counters entirely.

Structure
REQ-030 SHALL place in package dmux_pkg: the WIDTH default, LANES = 4, the entry typedef {sel[1:0], data[WIDTH-1:0]}, and a one-hot decode function.
REQ-031 SHALL instantiate the buffer as sub-module fifo2, a generic 2-entry valid/ready FIFO; routing and counters stay in dmux4_stream.

Verification
REQ-032 SHALL test: reset, then push data=16'hA5A5 with sel=2 while out_ready=4'b0100 -> out_valid=4'b0100 and out_data=16'hA5A5 one cycle later, popped on that edge.
REQ-033 SHALL test: out_ready=0, three consecutive pushes -> first two accepted, in_ready=0 on the third, the third is held by upstream.
REQ-034 SHALL test: head for lane 1 with out_ready=4'b1101 -> no pop, out_valid stays 4'b0010; setting out_ready[1]=1 pops it.
REQ-035 SHALL test: occupancy 1, simultaneous push (sel=3, 16'h1234) and pop -> occupancy stays 1, next out_valid=4'b1000, out_data=16'h1234.
REQ-036 SHALL test: FIFO full, then reset asserted asynchronously mid-cycle -> out_valid=0 immediately, in_ready=1 after release, no stale data delivered.
REQ-037 SHALL test, with DMUX_CNT_EN: 65537 pops to lane 0 -> cnt lane 0 = 1, other lanes = 0.
